// File: rtl/csi2_pkg.sv
// Shared CSI-2 receive definitions: header ECC table, ECC/CRC helpers, DT boundary, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package csi2_pkg;

  // Syndrome produced by a single flipped header data bit D0..D23 (D0 = B0[0]).
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  // Data types below this value are short packets.
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PYLD,
    ST_CRC,
    ST_SKIP
  } state_t;

  // 6-bit header ECC over {B2,B1,B0}.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] e;
    e = 6'h00;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) e = e ^ ECC_COL[i];
    end
    return e;
  endfunction

  // One byte of CRC-16 CCITT, reflected (x^16+x^12+x^5+1, bits taken LSB first).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_hdr_ecc.sv
// Combinational header syndrome check with single-bit correction.
// Latency: 0 cycles.
// Backpressure: none; pure function of the four header bytes.
module csi2_hdr_ecc
  import csi2_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [5:0]  b3,
  output logic [23:0] corrected,
  output logic        corr,
  output logic        err
);

  logic [23:0] data;
  logic [5:0]  syn;
  logic        hit;

  assign data = {b2, b1, b0};
  assign syn  = ecc6(data) ^ b3;

  // Match the syndrome against data columns (flip) or parity columns (one-hot, data kept).
  always_comb begin
    corrected = data;
    hit       = 1'b0;
    corr      = 1'b0;
    err       = 1'b0;
    if (syn != 6'h00) begin
      for (int i = 0; i < 24; i++) begin
        if (syn == ECC_COL[i]) begin
          corrected[i] = ~data[i];
          hit          = 1'b1;
        end
      end
      if ((syn & (syn - 6'd1)) == 6'h00) hit = 1'b1;
      corr = hit;
      err  = ~hit;
    end
  end

endmodule

// File: rtl/csi2_rx_hdr_decoder.sv
// CSI-2 receive packet parser: header ECC check/correct, payload forwarding, CRC-16 footer check.
// Latency: header strobes 1 cycle after B3, payload 1 cycle after the input byte.
// Backpressure: none; byte_vld_i low simply stalls parsing, hs_active_i low ends the burst.
module csi2_rx_hdr_decoder
  import csi2_pkg::*;
(
  input  logic        rx_clk_i,
  input  logic        reset_rx_n_i,
  input  logic        hs_active_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        d2c_sp_en_o,
  output logic        d2c_lp_en_o,
  output logic [7:0]  d2c_ph_o,
  output logic [15:0] d2c_wc_o,
  output logic        d2c_payload_en_o,
  output logic [7:0]  d2c_payload_o,
  output logic        ecc_corr_o,
  output logic        ecc_err_o,
  output logic        crc_err_o,
  output logic        trunc_err_o
);

  state_t      state;
  logic [1:0]  hdr_idx;
  logic [7:0]  b0, b1, b2;
  logic [15:0] cnt;
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic        crc_idx;

  logic [23:0] hdr_fix;
  logic        hdr_corr;
  logic        hdr_err;

  // B3 is taken straight from the byte bus so the decision lands on the cycle B3 arrives.
  csi2_hdr_ecc u_ecc (
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .b3        (byte_i[5:0]),
    .corrected (hdr_fix),
    .corr      (hdr_corr),
    .err       (hdr_err)
  );

  // Packet FSM with registered strobes and header/payload outputs.
  always_ff @(posedge rx_clk_i or negedge reset_rx_n_i) begin
    if (!reset_rx_n_i) begin
      state            <= ST_IDLE;
      hdr_idx          <= 2'd0;
      b0               <= 8'h00;
      b1               <= 8'h00;
      b2               <= 8'h00;
      cnt              <= 16'h0000;
      crc              <= 16'h0000;
      crc_lo           <= 8'h00;
      crc_idx          <= 1'b0;
      d2c_sp_en_o      <= 1'b0;
      d2c_lp_en_o      <= 1'b0;
      d2c_ph_o         <= 8'h00;
      d2c_wc_o         <= 16'h0000;
      d2c_payload_en_o <= 1'b0;
      d2c_payload_o    <= 8'h00;
      ecc_corr_o       <= 1'b0;
      ecc_err_o        <= 1'b0;
      crc_err_o        <= 1'b0;
      trunc_err_o      <= 1'b0;
    end else begin
      d2c_sp_en_o      <= 1'b0;
      d2c_lp_en_o      <= 1'b0;
      d2c_payload_en_o <= 1'b0;
      ecc_corr_o       <= 1'b0;
      ecc_err_o        <= 1'b0;
      crc_err_o        <= 1'b0;
      trunc_err_o      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hs_active_i && byte_vld_i) begin
            b0      <= byte_i;
            hdr_idx <= 2'd1;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!hs_active_i) begin
            // EoT between packets is normal; only a partly received header is truncated.
            trunc_err_o <= (hdr_idx != 2'd0);
            hdr_idx     <= 2'd0;
            state       <= ST_IDLE;
          end else if (byte_vld_i) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0:    b0 <= byte_i;
              2'd1:    b1 <= byte_i;
              2'd2:    b2 <= byte_i;
              default: begin
                if (hdr_err) begin
                  ecc_err_o <= 1'b1;
                  state     <= ST_SKIP;
                end else begin
                  ecc_corr_o <= hdr_corr;
                  d2c_ph_o   <= hdr_fix[7:0];
                  d2c_wc_o   <= hdr_fix[23:8];
                  if (hdr_fix[5:0] < DT_LONG_MIN) begin
                    d2c_sp_en_o <= 1'b1;
                  end else begin
                    d2c_lp_en_o <= 1'b1;
                    cnt         <= hdr_fix[23:8];
                    crc         <= 16'hFFFF;
                    crc_idx     <= 1'b0;
                    state       <= (hdr_fix[23:8] == 16'h0000) ? ST_CRC : ST_PYLD;
                  end
                end
              end
            endcase
          end
        end
        ST_PYLD: begin
          if (!hs_active_i) begin
            trunc_err_o <= 1'b1;
            state       <= ST_IDLE;
          end else if (byte_vld_i) begin
            d2c_payload_en_o <= 1'b1;
            d2c_payload_o    <= byte_i;
            crc              <= crc16_byte(crc, byte_i);
            cnt              <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              crc_idx <= 1'b0;
              state   <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (!hs_active_i) begin
            trunc_err_o <= 1'b1;
            state       <= ST_IDLE;
          end else if (byte_vld_i) begin
            if (!crc_idx) begin
              crc_lo  <= byte_i;
              crc_idx <= 1'b1;
            end else begin
              crc_err_o <= ({byte_i, crc_lo} != crc);
              crc_idx   <= 1'b0;
              hdr_idx   <= 2'd0;
              state     <= ST_HDR;
            end
          end
        end
        ST_SKIP: begin
          if (!hs_active_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
